// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the serial converter frame scheduler.
package conv_sched_pkg;

  localparam int unsigned DEF_FRAME_BITS = 16;
  localparam int unsigned DEF_CLK_DIV    = 4;

  localparam logic [1:0] MODE_BOTH = 2'b00;
  localparam logic [1:0] MODE_ADC  = 2'b01;
  localparam logic [1:0] MODE_DAC  = 2'b10;
  localparam logic [1:0] MODE_LOOP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADC_FRAME,
    GAP,
    DAC_FRAME,
    DONE
  } state_e;

endpackage

// File: rtl/conv_shift_engine.sv
// Shared serial frame engine: sclk divider, bit counter, TX/RX shift registers.
// One instance serves both ADC and DAC frames; dac_sel_i steers the TX bit.
module conv_shift_engine
  import conv_sched_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  dac_sel_i,
  input  logic [FRAME_BITS-1:0] load_word_i,
  input  logic                  rx_bit_i,
  output logic                  sclk_o,
  output logic                  adc_bit_o,
  output logic                  dac_bit_o,
  output logic [FRAME_BITS-1:0] rx_word_o,
  output logic                  frame_done_c
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned HALF_W = $clog2(2 * FRAME_BITS);

  logic                  active_q, active_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic                  sclk_q, sclk_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic                  dac_sel_q, dac_sel_d;
  logic                  adc_bit_q, dac_bit_q;

  // TX shifts on sclk rise, RX samples on sclk fall; last rise ends the frame.
  always_comb begin
    active_d     = active_q;
    div_d        = div_q;
    half_d       = half_q;
    sclk_d       = sclk_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    dac_sel_d    = dac_sel_q;
    frame_done_c = 1'b0;
    if (start_i) begin
      active_d  = 1'b1;
      div_d     = '0;
      half_d    = '0;
      sclk_d    = 1'b1;
      tx_d      = load_word_i;
      dac_sel_d = dac_sel_i;
    end else if (active_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d  = '0;
        half_d = half_q + HALF_W'(1);
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          rx_d = {rx_q[FRAME_BITS-2:0], rx_bit_i};
        end else begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          if (half_q == HALF_W'(2 * FRAME_BITS - 1)) begin
            active_d     = 1'b0;
            tx_d         = '0;
            frame_done_c = 1'b1;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      div_q     <= '0;
      half_q    <= '0;
      sclk_q    <= 1'b1;
      tx_q      <= '0;
      rx_q      <= '0;
      dac_sel_q <= 1'b0;
      adc_bit_q <= 1'b0;
      dac_bit_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      div_q     <= div_d;
      half_q    <= half_d;
      sclk_q    <= sclk_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dac_sel_q <= dac_sel_d;
      adc_bit_q <= active_d & ~dac_sel_d & tx_d[FRAME_BITS-1];
      dac_bit_q <= active_d & dac_sel_d & tx_d[FRAME_BITS-1];
    end
  end

  assign sclk_o    = sclk_q;
  assign adc_bit_o = adc_bit_q;
  assign dac_bit_o = dac_bit_q;
  assign rx_word_o = rx_q;

endmodule

// File: rtl/conv_serial_sched.sv
// Periodic ADC/DAC frame scheduler owning the shared serial converter bus.
// Optional CONV_SCHED_LOOPBACK_EN adds the lpbk self-test input.
module conv_serial_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned           CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned           FRAME_BITS    = DEF_FRAME_BITS,
  parameter int unsigned           SAMPLE_PERIOD = 1000,
  parameter logic [FRAME_BITS-1:0] ADC_CFG       = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [FRAME_BITS-1:0] dac_data,
  input  logic                  sdo_adc,
`ifdef CONV_SCHED_LOOPBACK_EN
  input  logic                  lpbk,
`endif
  output logic                  sclk,
  output logic                  ssync_adc,
  output logic                  ssync_dac,
  output logic                  sdi_adc,
  output logic                  sdo_dac,
  output logic [FRAME_BITS-1:0] adc_data,
  output logic                  adc_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned GAP_W  = $clog2(2 * CLK_DIV);

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  lpbk_q, lpbk_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  cap_pend_q, cap_pend_d;
  logic                  adc_valid_q, overrun_q, busy_q;
  logic                  ssync_adc_q, ssync_dac_q;
  logic [FRAME_BITS-1:0] adc_data_q;

  logic                  tick_c, lpbk_in_c;
  logic                  eng_start_c, eng_dac_c, eng_rx_bit_c, frame_done_c;
  logic [FRAME_BITS-1:0] eng_load_c, rx_word;

`ifdef CONV_SCHED_LOOPBACK_EN
  assign lpbk_in_c = lpbk;
`else
  assign lpbk_in_c = 1'b0;
`endif

  // Sample tick: fires on count SAMPLE_PERIOD-1, held at zero while disabled.
  always_comb begin
    tick_c     = en && (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));
    tick_cnt_d = (!en || tick_c) ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lpbk_d     = lpbk_q;
    gap_d      = gap_q;
    cap_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          mode_d = mode;
          lpbk_d = lpbk_in_c;
          case (mode)
            MODE_BOTH:           state_d = lpbk_in_c ? DAC_FRAME : ADC_FRAME;
            MODE_ADC:            state_d = ADC_FRAME;
            MODE_DAC, MODE_LOOP: state_d = DAC_FRAME;
          endcase
        end
      end
      ADC_FRAME: begin
        if (frame_done_c) begin
          cap_pend_d = 1'b1;
          if (mode_q == MODE_BOTH && !lpbk_q) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(2 * CLK_DIV - 1)) begin
          state_d = lpbk_q ? ADC_FRAME : DAC_FRAME;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DAC_FRAME: begin
        if (frame_done_c) begin
          if (mode_q == MODE_BOTH && lpbk_q) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine is (re)started on entry to either frame; the DAC word is latched then.
  always_comb begin
    eng_start_c  = (state_d != state_q) && (state_d == ADC_FRAME || state_d == DAC_FRAME);
    eng_dac_c    = (state_d == DAC_FRAME);
    eng_load_c   = ADC_CFG;
    if (state_d == DAC_FRAME) begin
      eng_load_c = (mode_d == MODE_LOOP) ? adc_data_q : dac_data;
    end
    eng_rx_bit_c = lpbk_q ? sdo_dac : sdo_adc;
  end

  conv_shift_engine #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_engine (
    .clk          (clk),
    .reset        (reset),
    .start_i      (eng_start_c),
    .dac_sel_i    (eng_dac_c),
    .load_word_i  (eng_load_c),
    .rx_bit_i     (eng_rx_bit_c),
    .sclk_o       (sclk),
    .adc_bit_o    (sdi_adc),
    .dac_bit_o    (sdo_dac),
    .rx_word_o    (rx_word),
    .frame_done_c (frame_done_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_BOTH;
      lpbk_q      <= 1'b0;
      gap_q       <= '0;
      tick_cnt_q  <= '0;
      cap_pend_q  <= 1'b0;
      adc_valid_q <= 1'b0;
      adc_data_q  <= '0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      ssync_adc_q <= 1'b1;
      ssync_dac_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lpbk_q      <= lpbk_d;
      gap_q       <= gap_d;
      tick_cnt_q  <= tick_cnt_d;
      cap_pend_q  <= cap_pend_d;
      adc_valid_q <= cap_pend_q;
      if (cap_pend_q) adc_data_q <= rx_word;
      if (tick_c && state_q != IDLE) overrun_q <= 1'b1;
      busy_q      <= (state_d != IDLE);
      ssync_adc_q <= (state_d != ADC_FRAME);
      ssync_dac_q <= (state_d != DAC_FRAME);
    end
  end

  assign ssync_adc = ssync_adc_q;
  assign ssync_dac = ssync_dac_q;
  assign adc_data  = adc_data_q;
  assign adc_valid = adc_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
